cm_sequencer: RTL and testbench

Instruction-issuing front end for the `cm` combinational unit. It holds a small loadable program and the three operand registers `R0`/`R1`/`R2`. Each instruction drives an opcode into `cm`, captures the returned `R_EXTRA`, and writes it back to a selected operand register. It is the initiator side of the `cm` interface: its `R0`, `R1`, `R2` and `opcode` outputs connect directly to `cm`'s inputs, and `cm`'s `R_EXTRA` connects back to this block.

---
 rtl/cm_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cm_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm_sequencer.sv
// -----------------------------------------------------------------------------
// cm_sequencer
//
// Instruction-issuing front end for the combinational `cm` unit. Holds a small
// loadable program plus the operand registers R0/R1/R2. Each non-halt
// instruction takes two cycles. In ISSUE it presents an opcode to `cm`. In
// CAPTURE it samples the returned R_EXTRA into `result` and writes it back to
// the selected operand register.
//
// Instruction word: [4] halt, [3:2] opcode, [1:0] dst (0=R0, 1=R1, 2=R2,
// 3=discard).
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   load_en      : write load_data into slot load_addr (IDLE only)
//   load_addr    : program slot to write
//   load_data    : instruction word to write
//   start        : run the program from slot 0 (IDLE only, a load wins)
//   R_EXTRA      : result returned by `cm`
//   R0, R1, R2   : operand registers, wired straight to `cm`
//   opcode       : opcode presented to `cm`
//   busy         : high while in ISSUE or CAPTURE
//   done         : one-cycle pulse when the program ends
//   result       : last captured R_EXTRA
//   result_valid : registered one-cycle pulse after each capture
// -----------------------------------------------------------------------------
module cm_sequencer #(
  parameter int PROG_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [4:0]    load_data,
  input  logic          start,
  input  logic [2:0]    R_EXTRA,
  output logic [2:0]    R0,
  output logic [2:0]    R1,
  output logic [2:0]    R2,
  output logic [1:0]    opcode,
  output logic          busy,
  output logic          done,
  output logic [2:0]    result,
  output logic          result_valid
);

  localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] pc;
  logic [4:0]    prog_mem [PROG_DEPTH];

  logic [4:0] instr;
  logic       instr_halt;
  logic [1:0] instr_op;
  logic [1:0] instr_dst;
  logic       start_accept;
  logic       pc_at_last;

  assign instr      = prog_mem[pc];
  assign instr_halt = instr[4];
  assign instr_op   = instr[3:2];
  assign instr_dst  = instr[1:0];

  // A simultaneous load takes priority, so start is dropped in that cycle.
  assign start_accept = (state == S_IDLE) && !load_en && start;
  assign pc_at_last   = (pc == PC_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (start_accept) state_next = S_ISSUE;
      S_ISSUE:   state_next = instr_halt ? S_DONE : S_CAPTURE;
      S_CAPTURE: state_next = pc_at_last ? S_DONE : S_ISSUE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_ISSUE, S_CAPTURE: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default:            ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pc, opcode, operand registers, captured result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      R0           <= 3'b001;
      R1           <= 3'b100;
      R2           <= 3'b010;
      opcode       <= 2'b00;
      result       <= 3'b000;
      result_valid <= 1'b0;
      pc           <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_accept) pc <= '0;
        end
        S_ISSUE: begin
          // A halt leaves the opcode as it was, so `cm` keeps its last input.
          if (!instr_halt) opcode <= instr_op;
        end
        S_CAPTURE: begin
          // `cm` has had a full cycle to settle on the opcode set in ISSUE.
          result       <= R_EXTRA;
          result_valid <= 1'b1;
          unique case (instr_dst)
            2'd0:    R0 <= R_EXTRA;
            2'd1:    R1 <= R_EXTRA;
            2'd2:    R2 <= R_EXTRA;
            default: ;
          endcase
          // No wrap-around: the last slot ends the program via DONE.
          if (!pc_at_last) pc <= pc + AW'(1);
        end
        S_DONE: begin
          pc <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Program memory
  // ---------------------------------------------------------------------------
  // NOTE: the program store has no reset, so it maps onto plain RAM and a
  // loaded program survives rst; only writes are gated.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_IDLE) && load_en) prog_mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_cm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cm_sequencer
//
// Self-checking bench for cm_sequencer. A stub of the `cm` unit drives R_EXTRA
// combinationally from the sequencer outputs. A transaction-level model runs
// the loaded program instruction by instruction. It also derives the cycle
// timing of busy/done/result_valid/opcode from the instruction count.
// -----------------------------------------------------------------------------
module tb_cm_sequencer;

  localparam int PD = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [4:0]    load_data;
  logic          start;
  logic [2:0]    r_extra;
  logic [2:0]    r0, r1, r2;
  logic [1:0]    opcode;
  logic          busy, done;
  logic [2:0]    result;
  logic          result_valid;
  logic [1:0]    stub_mode;

  always #5 clk = ~clk;

  cm_sequencer #(.PROG_DEPTH(PD), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .R_EXTRA      (r_extra),
    .R0           (r0),
    .R1           (r1),
    .R2           (r2),
    .opcode       (opcode),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid)
  );

  // Stand-in for the `cm` unit.
  function automatic logic [2:0] cm_stub(input logic [1:0] mode, input logic [1:0] op,
                                         input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] c);
    case (mode)
      2'd0:    return 3'b111;
      2'd1:    return 3'({1'b0, op} + 3'd4);
      2'd2:    return 3'(a + (b ^ c) + {1'b0, op});
      default: return 3'b000;
    endcase
  endfunction

  always_comb r_extra = cm_stub(stub_mode, opcode, r0, r1, r2);

  // Reference model state
  logic [4:0] m_mem [PD];
  logic [2:0] m_r   [3];
  logic [1:0] m_op;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic model_reset();
    m_r[0] = 3'b001;
    m_r[1] = 3'b100;
    m_r[2] = 3'b010;
    m_op   = 2'b00;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " R0"}, 32'(r0), 32'(m_r[0]));
    check({tag, " R1"}, 32'(r1), 32'(m_r[1]));
    check({tag, " R2"}, 32'(r2), 32'(m_r[2]));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    load_en = 1'b0;
    start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_regs("reset");
    check("reset opcode", 32'(opcode), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
  endtask

  task automatic load_slot(input logic [AW-1:0] addr, input logic [4:0] data, input bit with_start);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    start     = with_start;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    start   = 1'b0;
    m_mem[addr] = data;
    check("load busy", 32'(busy), 32'd0);
    if (with_start) begin
      @(posedge clk);
      #1;
      check("load+start busy", 32'(busy), 32'd0);
      check("load+start result_valid", 32'(result_valid), 32'd0);
    end
  endtask

  // Run the model over the program, then start the DUT and compare it cycle by
  // cycle. Sample t is taken 1 time unit after the t-th edge following the
  // start edge. Instruction i shows opcode at t=2i+1 and result_valid at
  // t=2i+2. done comes one cycle after the last CAPTURE, or one cycle after the
  // halting ISSUE.
  task automatic run_program(input string name, input bit noise);
    int         n;
    bit         halted;
    int         t_done;
    logic [2:0] er [PD];
    logic [2:0] es [PD][3];
    logic [1:0] eo [PD];

    n      = 0;
    halted = 1'b0;
    for (int k = 0; k < PD; k++) begin
      if (m_mem[k][4]) begin
        halted = 1'b1;
        break;
      end
      eo[n] = m_mem[k][3:2];
      er[n] = cm_stub(stub_mode, eo[n], m_r[0], m_r[1], m_r[2]);
      case (m_mem[k][1:0])
        2'd0:    m_r[0] = er[n];
        2'd1:    m_r[1] = er[n];
        2'd2:    m_r[2] = er[n];
        default: ;
      endcase
      for (int j = 0; j < 3; j++) es[n][j] = m_r[j];
      m_op = eo[n];
      n++;
    end
    t_done = halted ? 2 * n + 1 : 2 * n;

    load_en = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int t = 0; t <= t_done + 1; t++) begin
      bit rv_exp;
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      rv_exp = (t >= 2) && (t % 2 == 0) && (t / 2 - 1 < n);
      check($sformatf("%s busy t=%0d", name, t), 32'(busy), 32'(t < t_done));
      check($sformatf("%s done t=%0d", name, t), 32'(done), 32'(t == t_done));
      check($sformatf("%s result_valid t=%0d", name, t), 32'(result_valid), 32'(rv_exp));
      if (rv_exp) begin
        int i;
        i = t / 2 - 1;
        check($sformatf("%s result i=%0d", name, i), 32'(result), 32'(er[i]));
        check($sformatf("%s R0 i=%0d", name, i), 32'(r0), 32'(es[i][0]));
        check($sformatf("%s R1 i=%0d", name, i), 32'(r1), 32'(es[i][1]));
        check($sformatf("%s R2 i=%0d", name, i), 32'(r2), 32'(es[i][2]));
      end
      if ((t % 2 == 1) && ((t - 1) / 2 < n))
        check($sformatf("%s opcode i=%0d", name, (t - 1) / 2), 32'(opcode), 32'(eo[(t - 1) / 2]));
      // Loads and starts while busy must be ignored; stop before IDLE returns.
      if (noise && t < t_done) begin
        load_en   = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        load_addr = AW'($urandom);
        load_data = 5'($urandom);
      end else begin
        load_en = 1'b0;
        start   = 1'b0;
      end
    end
    check_regs({name, " final"});
    check({name, " final opcode"}, 32'(opcode), 32'(m_op));
  endtask

  initial begin
    rst       = 1'b1;
    load_en   = 1'b0;
    start     = 1'b0;
    load_addr = '0;
    load_data = '0;
    stub_mode = 2'd0;

    // Reset values
    do_reset();

    // Single instruction into R2, then halt
    stub_mode = 2'd0;
    load_slot(3'd0, 5'b0_01_10, 1'b0);
    load_slot(3'd1, 5'b1_00_00, 1'b0);
    run_program("single", 1'b0);
    check("single R2 const", 32'(r2), 32'h7);
    check("single result const", 32'(result), 32'h7);

    // Opcode sweep into dst=3
    stub_mode = 2'd1;
    for (int op = 0; op < 4; op++) load_slot(AW'(op), {1'b0, 2'(op), 2'b11}, 1'b0);
    load_slot(3'd4, 5'b1_00_00, 1'b0);
    run_program("sweep", 1'b0);
    check("sweep last result const", 32'(result), 32'h7);

    // Full program, no halt bit anywhere
    stub_mode = 2'd2;
    for (int k = 0; k < PD; k++) load_slot(AW'(k), {1'b0, 4'($urandom)}, 1'b0);
    run_program("full", 1'b0);
    run_program("full_again", 1'b0);

    // load_en with start in IDLE: load only
    load_slot(3'd3, {1'b0, 4'($urandom)}, 1'b1);
    // load_en/start while busy: ignored
    run_program("busy_noise", 1'b1);

    // Reset in the middle of a CAPTURE targeting R0
    stub_mode = 2'd3;
    load_slot(3'd0, 5'b0_10_00, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midrst opcode in capture", 32'(opcode), 32'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("midrst R0", 32'(r0), 32'h1);
    check("midrst result_valid", 32'(result_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst opcode", 32'(opcode), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst result_valid after", 32'(result_valid), 32'd0);
    check("midrst done after", 32'(done), 32'd0);
    check("midrst R0 after", 32'(r0), 32'h1);
    stub_mode = 2'd2;
    run_program("rerun", 1'b0);

    // Random programs with random halts and bus noise
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < PD; k++)
        load_slot(AW'(k), {1'($urandom_range(0, 3) == 0), 4'($urandom)}, 1'b0);
      stub_mode = 2'($urandom_range(0, 2));
      run_program($sformatf("rand%0d", it), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
